int_seq_ctrl: RTL

INT_SEQ_CTRL -- requirements
Module: int_seq_ctrl

---
 rtl/int_seq_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/int_seq_ctrl.sv
// rtl/int_seq_ctrl.sv - interrupt entry sequencer: edge latch, fixed-priority arbitration, flush/break/service FSM
module int_seq_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int NUM_SRC      = 3
) (
    input  logic               in_CLK,
    input  logic               in_RST,
    input  logic [NUM_SRC-1:0] in_IRQ,
    input  logic               in_IE,
    input  logic [3:0]         in_INM,
    input  logic               in_eret,
    input  logic               in_STALL,
    output logic               out_FLUSH,
    output logic               out_BK,
    output logic               out_NIE,
    output logic [1:0]         out_code,
    output logic [NUM_SRC-1:0] out_PENDING,
    output logic               out_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_ENTER   = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

    // FLUSH_CYCLES is expected in 1..15 so it fits the 4-bit flush counter
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES);

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [NUM_SRC-1:0] armed_q, armed_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [1:0]         win_q, win_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] elig;
    logic               any_elig;
    logic [1:0]         win_sel;
    logic [3:0]         cnt_inc;

    // Mask bit 3 has no source behind it
    logic unused_inm;
    assign unused_inm = in_INM[3];

    // State and datapath registers; armed tracks lines seen low since reset so a
    // line held high across reset release cannot fake a rising edge
    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            state_q <= ST_IDLE;
            prev_q  <= '0;
            armed_q <= ~in_IRQ;
            pend_q  <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
        end
    end

    // Edge detection, eligibility and fixed-priority winner (highest index wins)
    always_comb begin
        rise     = in_IRQ & ~prev_q & armed_q;
        elig     = in_IE ? (pend_q & ~in_INM[NUM_SRC-1:0]) : '0;
        any_elig = |elig;
        win_sel  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (elig[k]) begin
                win_sel = 2'(k);
            end
        end
    end

    // Next-state logic; once committed to FLUSH the sequence always completes
    always_comb begin
        state_d = state_q;
        cnt_inc = cnt_q + (in_STALL ? 4'd0 : 4'd1);
        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt_inc == FLUSH_LAST) begin
                    state_d = ST_ENTER;
                end
            end
            ST_ENTER: begin
                state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (in_eret) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: pending set beats clear, winner latched on entry to FLUSH
    always_comb begin
        clr = '0;
        if (state_q == ST_ENTER) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (win_q == 2'(k)) begin
                    clr[k] = 1'b1;
                end
            end
        end
        prev_d  = in_IRQ;
        armed_d = armed_q | ~in_IRQ;
        pend_d  = (pend_q & ~clr) | rise;
        win_d   = ((state_q == ST_IDLE) && any_elig) ? win_sel : win_q;
        cnt_d   = ((state_q == ST_FLUSH) && (state_d == ST_FLUSH)) ? cnt_inc : 4'd0;
    end

    // Moore outputs decoded from state and registers
    always_comb begin
        out_FLUSH   = (state_q == ST_FLUSH);
        out_BK      = (state_q == ST_ENTER);
        out_NIE     = (state_q != ST_ENTER);
        out_code    = (state_q == ST_ENTER) ? (win_q + 2'd1) : 2'd0;
        out_PENDING = pend_q;
        out_BUSY    = (state_q != ST_IDLE);
    end

endmodule
